rtc_counter: RTL and testbench
==============================

// Module: rtc_counter
// PURPOSE
//  Free-running real-time clock/calendar. Produces the packed time/date words consumed by
//  TIME_CONT (IN_TIME/IN_DATE) and the display path. Divides CLK down to a one-second tick and
//  advances sec/min/hour/AM-PM/day/month/year with month-length and leap-year rules.
//  Accepts a one-cycle LOAD of user-edited time/date (TIME_CONT OUT_TIME/OUT_DATE).
// PARAMETERS
//  CLK_DIV    1000  CLK cycles per second tick (>=2)
//  DIV_W      10    prescaler width, 2**DIV_W >= CLK_DIV
// PORTS
//  CLK        in   1   system clock, all state on rising edge
//  RESETN     in   1   asynchronous active-low reset
//  RUN        in   1   1 = clock advances; 0 = frozen, prescaler held
//  LOAD       in   1   one-cycle strobe: capture LOAD_TIME/LOAD_DATE
//  LOAD_TIME  in   17  {MERIDIAN[16], HOUR[15:12], MIN[11:6], SEC[5:0]}
//  LOAD_DATE  in   17  {YEAR[16:10], MONTH[9:5], DAY[4:0]}
//  TIME       out  17  current time, same packing as LOAD_TIME
//  DATE       out  17  current date, same packing as LOAD_DATE
//  SEC_TICK   out  1   one-cycle pulse each time SEC advances
//  DAY_TICK   out  1   one-cycle pulse when the date advances (12:00:00 AM rollover)
// BEHAVIOUR
//  Reset (async, RESETN=0): TIME = 12:00:00 AM (MER=0,HOUR=12,MIN=0,SEC=0); DATE = year 0,
//   month 1, day 1; prescaler=0; SEC_TICK=DAY_TICK=0. All outputs are registered.
//  MERIDIAN: 0=AM, 1=PM. HOUR range 1..12 (12-hour), MIN/SEC 0..59, YEAR 0..99 (=2000..2099),
//   MONTH 1..12, DAY 1..days_in_month.
//  Prescaler: when RUN=1, counts 0..CLK_DIV-1 and wraps; terminal count (CLK_DIV-1) = tick.
//   At the edge where the tick is seen, time advances; SEC_TICK is high the following cycle.
//   RUN=0: prescaler holds its value, no advance, SEC_TICK=0.
//  Carry chain, all in the same edge as the tick:
//   SEC 59->0 carries MIN; MIN 59->0 carries HOUR.
//   HOUR 12->1 (no meridian change); HOUR 11->12 toggles MERIDIAN.
//   11:59:59 PM -> 12:00:00 AM also advances the date and pulses DAY_TICK.
//  Date: days_in_month = 31 (1,3,5,7,8,10,12), 30 (4,6,9,11), Feb 29 if YEAR%4==0 else 28.
//   DAY==days_in_month -> DAY=1, MONTH+1; MONTH 12->1, YEAR+1; YEAR 99->0.
//  LOAD (priority over tick in the same cycle): TIME/DATE take sanitized load values next edge,
//   prescaler cleared to 0, no SEC_TICK/DAY_TICK that cycle. LOAD is honoured with RUN=0.
//  Sanitizing: SEC/MIN >59 -> 0; HOUR 0 or >12 -> 12; YEAR >99 -> 0; MONTH 0 or >12 -> 1;
//   DAY 0 -> 1; DAY > days_in_month(loaded MONTH,YEAR) -> days_in_month. MERIDIAN taken as-is.
//  Arithmetic: pure binary fields, no BCD; widths fixed as packed, no overflow beyond ranges.
//  Reset asserted mid-second discards prescaler progress; deassert restarts from count 0.
//  Implementation: prescaler counter + registered field counters + combinational
//   days_in_month/leap function; separate one-cycle pulse registers for the tick outputs.
// TESTING (CLK_DIV=4 unless stated)
//  1. Reset then RUN=1 for 4 cycles -> TIME 12:00:01 AM, SEC_TICK one cycle, DATE 00/01/01.
//  2. LOAD 11:59:59 AM, tick -> 12:00:00 PM, DATE unchanged, DAY_TICK=0; next to 12:59:59 PM
//     + tick -> 01:00:00 PM.
//  3. LOAD 11:59:59 PM, date 23/12/31, tick -> 12:00:00 AM, DATE 24/01/01, DAY_TICK one cycle.
//  4. Leap: LOAD 11:59:59 PM 24/02/28 tick -> 24/02/29; LOAD 23/02/28 same -> 23/03/01;
//     LOAD 99/12/31 rollover -> 00/01/01.
//  5. LOAD same cycle as terminal count with 03:15:20 PM -> exactly 03:15:20 PM, no SEC_TICK,
//     next advance 4 cycles later; RUN=0 for 20 cycles -> no change.
//  6. Sanitize: LOAD HOUR=0,MIN=63,DATE 23/02/30 -> 12:00:xx, DATE 23/02/28; RESETN low
//     mid-second -> outputs return to reset values immediately (async).

Source files
------------

// File: rtl/rtc_counter.sv
// Real-time clock/calendar: prescaled one-second tick driving a 12-hour time
// counter and a 2000..2099 date counter, with a sanitized one-cycle load.
module rtc_counter #(
  parameter int CLK_DIV = 1000,
  parameter int DIV_W   = 10
) (
  input  logic        CLK,
  input  logic        RESETN,
  input  logic        RUN,
  input  logic        LOAD,
  input  logic [16:0] LOAD_TIME,
  input  logic [16:0] LOAD_DATE,
  output logic [16:0] TIME,
  output logic [16:0] DATE,
  output logic        SEC_TICK,
  output logic        DAY_TICK
);

  typedef struct packed {
    logic       mer;
    logic [3:0] hour;
    logic [5:0] min;
    logic [5:0] sec;
  } rtc_time_t;

  typedef struct packed {
    logic [6:0] year;
    logic [4:0] month;
    logic [4:0] day;
  } rtc_date_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  function automatic logic [4:0] days_in_month(input logic [4:0] month,
                                               input logic [6:0] year);
    case (month)
      5'd4, 5'd6, 5'd9, 5'd11: days_in_month = 5'd30;
      5'd2:                    days_in_month = (year[1:0] == 2'd0) ? 5'd29 : 5'd28;
      default:                 days_in_month = 5'd31;
    endcase
  endfunction

  logic [DIV_W-1:0] div_cnt;
  rtc_time_t        cur_t, nx_t, ld_t;
  rtc_date_t        cur_d, nx_d, ld_d;
  logic [4:0]       cur_dim, ld_dim;
  logic             tick, day_roll;
  logic             sec_tick_q, day_tick_q;

  assign tick = RUN && (div_cnt == DIV_LAST);

  // Load sanitizing; day is clamped against the already-sanitized month/year.
  always_comb begin
    ld_t = rtc_time_t'(LOAD_TIME);
    ld_d = rtc_date_t'(LOAD_DATE);
    if (ld_t.sec > 6'd59) ld_t.sec = 6'd0;
    if (ld_t.min > 6'd59) ld_t.min = 6'd0;
    if (ld_t.hour == 4'd0 || ld_t.hour > 4'd12) ld_t.hour = 4'd12;
    if (ld_d.year > 7'd99) ld_d.year = 7'd0;
    if (ld_d.month == 5'd0 || ld_d.month > 5'd12) ld_d.month = 5'd1;
    ld_dim = days_in_month(ld_d.month, ld_d.year);
    if (ld_d.day == 5'd0) ld_d.day = 5'd1;
    else if (ld_d.day > ld_dim) ld_d.day = ld_dim;
  end

  // One-second advance: full sec->min->hour->date carry chain in one step.
  always_comb begin
    nx_t     = cur_t;
    nx_d     = cur_d;
    day_roll = 1'b0;
    cur_dim  = days_in_month(cur_d.month, cur_d.year);
    if (cur_t.sec == 6'd59) begin
      nx_t.sec = 6'd0;
      if (cur_t.min == 6'd59) begin
        nx_t.min = 6'd0;
        if (cur_t.hour == 4'd12) begin
          nx_t.hour = 4'd1;
        end else begin
          nx_t.hour = cur_t.hour + 4'd1;
          if (cur_t.hour == 4'd11) begin
            nx_t.mer = ~cur_t.mer;
            day_roll = cur_t.mer;
          end
        end
      end else begin
        nx_t.min = cur_t.min + 6'd1;
      end
    end else begin
      nx_t.sec = cur_t.sec + 6'd1;
    end
    if (day_roll) begin
      if (cur_d.day >= cur_dim) begin
        nx_d.day = 5'd1;
        if (cur_d.month >= 5'd12) begin
          nx_d.month = 5'd1;
          nx_d.year  = (cur_d.year >= 7'd99) ? 7'd0 : cur_d.year + 7'd1;
        end else begin
          nx_d.month = cur_d.month + 5'd1;
        end
      end else begin
        nx_d.day = cur_d.day + 5'd1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      div_cnt    <= '0;
      cur_t      <= '{mer: 1'b0, hour: 4'd12, min: 6'd0, sec: 6'd0};
      cur_d      <= '{year: 7'd0, month: 5'd1, day: 5'd1};
      sec_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
    end else if (LOAD) begin
      div_cnt    <= '0;
      cur_t      <= ld_t;
      cur_d      <= ld_d;
      sec_tick_q <= 1'b0;
      day_tick_q <= 1'b0;
    end else begin
      sec_tick_q <= tick;
      day_tick_q <= tick && day_roll;
      if (RUN) begin
        if (tick) begin
          div_cnt <= '0;
          cur_t   <= nx_t;
          cur_d   <= nx_d;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end
    end
  end

  assign TIME     = cur_t;
  assign DATE     = cur_d;
  assign SEC_TICK = sec_tick_q;
  assign DAY_TICK = day_tick_q;

endmodule

// File: tb/tb_rtc_counter.sv
// Bench for rtc_counter: directed calendar corner cases plus randomized run/load
// traffic, checked against a seconds-of-day / calendar reference model.
module tb_rtc_counter;
  localparam int CLK_DIV = 4;
  localparam int DIV_W   = 3;

  logic        CLK = 1'b0;
  logic        RESETN = 1'b0;
  logic        RUN = 1'b0;
  logic        LOAD = 1'b0;
  logic [16:0] LOAD_TIME = '0;
  logic [16:0] LOAD_DATE = '0;
  logic [16:0] TIME, DATE;
  logic        SEC_TICK, DAY_TICK;

  int checks = 0;
  int errors = 0;

  // reference state
  int sod, yr, mo, dy, pcnt;
  bit exp_st, exp_dt;
  int mdays[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};

  rtc_counter #(.CLK_DIV(CLK_DIV), .DIV_W(DIV_W)) dut (
    .CLK(CLK), .RESETN(RESETN), .RUN(RUN), .LOAD(LOAD),
    .LOAD_TIME(LOAD_TIME), .LOAD_DATE(LOAD_DATE),
    .TIME(TIME), .DATE(DATE), .SEC_TICK(SEC_TICK), .DAY_TICK(DAY_TICK)
  );

  always #5 CLK = ~CLK;

  function automatic int dim_ref(int m, int y);
    return (m == 2 && y % 4 == 0) ? 29 : mdays[m-1];
  endfunction

  function automatic logic [16:0] mk_t(bit mer, int h, int m, int s);
    return {mer, 4'(h), 6'(m), 6'(s)};
  endfunction

  function automatic logic [16:0] mk_d(int y, int m, int d);
    return {7'(y), 5'(m), 5'(d)};
  endfunction

  function automatic logic [16:0] exp_time();
    int h24, h12;
    h24 = sod / 3600;
    h12 = (h24 % 12 == 0) ? 12 : h24 % 12;
    return mk_t(h24 >= 12, h12, (sod / 60) % 60, sod % 60);
  endfunction

  task automatic chk(string tag, logic [16:0] obs, logic [16:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    sod = 0; yr = 0; mo = 1; dy = 1; pcnt = 0; exp_st = 0; exp_dt = 0;
  endtask

  task automatic model_load(logic [16:0] t, logic [16:0] d);
    int s, m, h, h24;
    s = int'(t[5:0]); m = int'(t[11:6]); h = int'(t[15:12]);
    if (s > 59) s = 0;
    if (m > 59) m = 0;
    if (h == 0 || h > 12) h = 12;
    h24 = (h % 12) + (t[16] ? 12 : 0);
    sod = h24 * 3600 + m * 60 + s;
    yr = int'(d[16:10]); mo = int'(d[9:5]); dy = int'(d[4:0]);
    if (yr > 99) yr = 0;
    if (mo == 0 || mo > 12) mo = 1;
    if (dy == 0) dy = 1;
    else if (dy > dim_ref(mo, yr)) dy = dim_ref(mo, yr);
  endtask

  task automatic model_second();
    sod++;
    if (sod == 86400) begin
      sod = 0;
      exp_dt = 1;
      dy++;
      if (dy > dim_ref(mo, yr)) begin
        dy = 1; mo++;
        if (mo > 12) begin mo = 1; yr = (yr + 1) % 100; end
      end
    end
  endtask

  // one clock: model uses the inputs present at the edge, checks at edge+1
  task automatic cyc(string tag);
    @(posedge CLK);
    exp_st = 0; exp_dt = 0;
    if (LOAD) begin
      model_load(LOAD_TIME, LOAD_DATE);
      pcnt = 0;
    end else if (RUN) begin
      if (pcnt == CLK_DIV - 1) begin
        pcnt = 0; exp_st = 1; model_second();
      end else pcnt++;
    end
    #1;
    chk({tag, "_time"}, TIME, exp_time());
    chk({tag, "_date"}, DATE, mk_d(yr, mo, dy));
    chk({tag, "_stick"}, 17'(SEC_TICK), 17'(exp_st));
    chk({tag, "_dtick"}, 17'(DAY_TICK), 17'(exp_dt));
  endtask

  task automatic cycles(string tag, int n);
    for (int i = 0; i < n; i++) cyc(tag);
  endtask

  task automatic do_load(string tag, logic [16:0] t, logic [16:0] d);
    LOAD = 1; LOAD_TIME = t; LOAD_DATE = d;
    cyc(tag);
    LOAD = 0;
  endtask

  initial begin
    logic [16:0] rt, rd;
    int k;
    model_reset();
    #12;
    chk("rst_time", TIME, mk_t(0, 12, 0, 0));
    chk("rst_date", DATE, mk_d(0, 1, 1));
    chk("rst_ticks", {15'd0, SEC_TICK, DAY_TICK}, 17'd0);
    @(negedge CLK); RESETN = 1; RUN = 1;

    // 1: first second after reset
    cycles("t1", 3);
    chk("t1_pre", TIME, mk_t(0, 12, 0, 0));
    cyc("t1");
    chk("t1_sec1", TIME, mk_t(0, 12, 0, 1));
    cyc("t1");
    chk("t1_stick_off", 17'(SEC_TICK), 17'd0);

    // 2: noon meridian flip, 12 -> 1
    do_load("t2", mk_t(0, 11, 59, 59), mk_d(5, 6, 15));
    cycles("t2", 4);
    chk("t2_noon", TIME, mk_t(1, 12, 0, 0));
    chk("t2_date", DATE, mk_d(5, 6, 15));
    do_load("t2b", mk_t(1, 12, 59, 59), mk_d(5, 6, 15));
    cycles("t2b", 4);
    chk("t2_one", TIME, mk_t(1, 1, 0, 0));

    // 3: new year
    do_load("t3", mk_t(1, 11, 59, 59), mk_d(23, 12, 31));
    cycles("t3", 4);
    chk("t3_time", TIME, mk_t(0, 12, 0, 0));
    chk("t3_date", DATE, mk_d(24, 1, 1));
    chk("t3_dtick", 17'(DAY_TICK), 17'd1);
    cyc("t3");

    // 4: leap rules and century wrap
    do_load("t4a", mk_t(1, 11, 59, 59), mk_d(24, 2, 28));
    cycles("t4a", 4);
    chk("t4_leap", DATE, mk_d(24, 2, 29));
    do_load("t4b", mk_t(1, 11, 59, 59), mk_d(23, 2, 28));
    cycles("t4b", 4);
    chk("t4_noleap", DATE, mk_d(23, 3, 1));
    do_load("t4c", mk_t(1, 11, 59, 59), mk_d(99, 12, 31));
    cycles("t4c", 4);
    chk("t4_wrap", DATE, mk_d(0, 1, 1));

    // 5: load beats a coincident terminal count; RUN=0 freezes
    cycles("t5", 3);
    do_load("t5", mk_t(1, 3, 15, 20), mk_d(10, 10, 10));
    chk("t5_load", TIME, mk_t(1, 3, 15, 20));
    chk("t5_nostick", 17'(SEC_TICK), 17'd0);
    cycles("t5", 3);
    chk("t5_hold", TIME, mk_t(1, 3, 15, 20));
    cyc("t5");
    chk("t5_adv", TIME, mk_t(1, 3, 15, 21));
    cycles("t5", 2);
    RUN = 0;
    cycles("t5_frz", 20);
    chk("t5_frozen", TIME, mk_t(1, 3, 15, 21));
    RUN = 1;
    cycles("t5_resume", 3);

    // 6: sanitize, then async reset mid-second
    do_load("t6", mk_t(0, 0, 63, 7), mk_d(23, 2, 30));
    chk("t6_time", TIME, mk_t(0, 12, 0, 7));
    chk("t6_date", DATE, mk_d(23, 2, 28));
    do_load("t6b", mk_t(1, 15, 40, 61), mk_d(120, 0, 0));
    chk("t6b_time", TIME, mk_t(1, 12, 40, 0));
    chk("t6b_date", DATE, mk_d(0, 1, 1));
    cycles("t6", 6);
    #2 RESETN = 0;
    #1;
    chk("t6_arst_time", TIME, mk_t(0, 12, 0, 0));
    chk("t6_arst_date", DATE, mk_d(0, 1, 1));
    chk("t6_arst_ticks", {15'd0, SEC_TICK, DAY_TICK}, 17'd0);
    model_reset();
    @(negedge CLK); RESETN = 1;
    cycles("t6_restart", 5);

    // randomized traffic
    for (int i = 0; i < 4000; i++) begin
      RUN = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) begin
        k = $urandom_range(0, 2);
        if (k == 0) begin
          rt = 17'($urandom); rd = 17'($urandom);
        end else begin
          int y, m;
          y = $urandom_range(0, 99); m = $urandom_range(1, 12);
          rt = mk_t(k == 1, 11, 59, $urandom_range(50, 59));
          rd = mk_d(y, m, dim_ref(m, y) - $urandom_range(0, 1));
        end
        do_load("rnd_ld", rt, rd);
      end else begin
        cyc("rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end
endmodule
